// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the load queue and the store commit buffer.
// Loads have priority; a saturating starvation counter forces a store through after STARVE_MAX load grants.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int TAG_W      = 4,
    parameter int STARVE_MAX = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             ld_req_valid,
    output logic             ld_req_ready,
    input  logic [31:0]      ld_addr,
    input  logic [TAG_W-1:0] ld_tag,
    input  logic             st_req_valid,
    output logic             st_req_ready,
    input  logic [31:0]      st_addr,
    input  logic [31:0]      st_data,
    input  logic [1:0]       st_size,
    input  logic             flush,
    output logic             ld_resp_valid,
    output logic [31:0]      ld_resp_data,
    output logic [TAG_W-1:0] ld_resp_tag,
    output logic             st_done,
    output logic [31:0]      data_address_2DM,
    output logic [31:0]      data_write_2DM,
    output logic [1:0]       data_write_size_2DM,
    output logic             MemRead_2DM,
    output logic             MemWrite_2DM,
    input  logic [31:0]      data_read_fDM
);
    localparam int LAT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STV_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(MEM_LAT - 1);
    localparam logic [STV_W-1:0] STV_LIM  = STV_W'(STARVE_MAX);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t           state_q, state_d;
    logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
    logic [STV_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             kill_q, kill_d;
    logic             is_store_q, is_store_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [31:0]      mem_wdata_q, mem_wdata_d;
    logic [1:0]       mem_size_q, mem_size_d;
    logic             mem_read_q, mem_read_d;
    logic             mem_write_q, mem_write_d;
    logic             ld_resp_valid_q, ld_resp_valid_d;
    logic [31:0]      ld_resp_data_q, ld_resp_data_d;
    logic [TAG_W-1:0] ld_resp_tag_q, ld_resp_tag_d;
    logic             st_done_q, st_done_d;
    logic             idle, sel_ld, sel_st;
    logic             unused_ld_addr_lsbs;

    // Loads are forwarded word-aligned, so the byte-offset bits are dropped.
    assign unused_ld_addr_lsbs = ^ld_addr[1:0];

    assign idle   = (state_q == IDLE) && !RESET;
    assign sel_st = idle && st_req_valid && (!ld_req_valid || (starve_cnt_q == STV_LIM) || flush);
    assign sel_ld = idle && !sel_st && ld_req_valid && !flush;

    assign ld_req_ready        = sel_ld;
    assign st_req_ready        = sel_st;
    assign ld_resp_valid       = ld_resp_valid_q;
    assign ld_resp_data        = ld_resp_data_q;
    assign ld_resp_tag         = ld_resp_tag_q;
    assign st_done             = st_done_q;
    assign data_address_2DM    = mem_addr_q;
    assign data_write_2DM      = mem_wdata_q;
    assign data_write_size_2DM = mem_size_q;
    assign MemRead_2DM         = mem_read_q;
    assign MemWrite_2DM        = mem_write_q;

    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no branch can leave a latch behind.
        state_d         = state_q;
        lat_cnt_d       = lat_cnt_q;
        starve_cnt_d    = starve_cnt_q;
        kill_d          = kill_q;
        is_store_d      = is_store_q;
        tag_d           = tag_q;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;
        mem_size_d      = mem_size_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        ld_resp_valid_d = 1'b0;
        ld_resp_data_d  = ld_resp_data_q;
        ld_resp_tag_d   = ld_resp_tag_q;
        st_done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (sel_ld) begin
                    state_d     = ACCESS;
                    lat_cnt_d   = LAT_INIT;
                    kill_d      = 1'b0;
                    is_store_d  = 1'b0;
                    tag_d       = ld_tag;
                    mem_addr_d  = {ld_addr[31:2], 2'b00};
                    mem_wdata_d = '0;
                    mem_size_d  = '0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    if (st_req_valid) begin
                        starve_cnt_d = (starve_cnt_q == STV_LIM) ? STV_LIM : starve_cnt_q + 1'b1;
                    end
                end else if (sel_st) begin
                    state_d      = ACCESS;
                    lat_cnt_d    = LAT_INIT;
                    kill_d       = 1'b0;
                    is_store_d   = 1'b1;
                    mem_addr_d   = st_addr;
                    mem_wdata_d  = st_data;
                    mem_size_d   = st_size;
                    mem_read_d   = 1'b0;
                    mem_write_d  = 1'b1;
                    starve_cnt_d = '0;
                end
            end
            ACCESS: begin
                if (flush && !is_store_q) begin
                    kill_d = 1'b1;
                end
                if (lat_cnt_q == '0) begin
                    state_d     = IDLE;
                    kill_d      = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    mem_size_d  = '0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (is_store_q) begin
                        st_done_d = 1'b1;
                    end else begin
                        // A flush on the completing cycle kills the response just like an earlier one.
                        ld_resp_valid_d = !kill_q && !flush;
                        ld_resp_data_d  = data_read_fDM;
                        ld_resp_tag_d   = tag_q;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            lat_cnt_q       <= '0;
            starve_cnt_q    <= '0;
            kill_q          <= 1'b0;
            is_store_q      <= 1'b0;
            tag_q           <= '0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
            mem_size_q      <= '0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            ld_resp_valid_q <= 1'b0;
            ld_resp_data_q  <= '0;
            ld_resp_tag_q   <= '0;
            st_done_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            lat_cnt_q       <= lat_cnt_d;
            starve_cnt_q    <= starve_cnt_d;
            kill_q          <= kill_d;
            is_store_q      <= is_store_d;
            tag_q           <= tag_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
            mem_size_q      <= mem_size_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            ld_resp_valid_q <= ld_resp_valid_d;
            ld_resp_data_q  <= ld_resp_data_d;
            ld_resp_tag_q   <= ld_resp_tag_d;
            st_done_q       <= st_done_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: the requester side pushes expected memory cycles and
// responses when a grant is predicted; a forked monitor pops and compares them every cycle.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    localparam int MEM_LAT    = 2;
    localparam int TAG_W      = 4;
    localparam int STARVE_MAX = 3;
    localparam int SCHED_LEN  = 4096;

    logic             CLK, RESET;
    logic             ld_req_valid, ld_req_ready, st_req_valid, st_req_ready;
    logic [31:0]      ld_addr, st_addr, st_data;
    logic [TAG_W-1:0] ld_tag, ld_resp_tag;
    logic [1:0]       st_size, data_write_size_2DM;
    logic             flush, ld_resp_valid, st_done, MemRead_2DM, MemWrite_2DM;
    logic [31:0]      ld_resp_data, data_address_2DM, data_write_2DM, data_read_fDM;

    mem_port_arbiter #(.MEM_LAT(MEM_LAT), .TAG_W(TAG_W), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .RESET(RESET),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
        .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_addr(st_addr),
        .st_data(st_data), .st_size(st_size), .flush(flush),
        .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data), .ld_resp_tag(ld_resp_tag),
        .st_done(st_done), .data_address_2DM(data_address_2DM), .data_write_2DM(data_write_2DM),
        .data_write_size_2DM(data_write_size_2DM), .MemRead_2DM(MemRead_2DM),
        .MemWrite_2DM(MemWrite_2DM), .data_read_fDM(data_read_fDM)
    );

    typedef struct packed {
        logic [31:0] cyc; logic [31:0] addr; logic [31:0] wdata; logic [1:0] size; logic rd; logic wr;
    } mem_op_t;
    typedef struct packed { logic [31:0] cyc; logic [31:0] data; logic [TAG_W-1:0] tag; } ld_rsp_t;
    typedef struct packed { logic [31:0] addr; logic [TAG_W-1:0] tag; } ld_req_t;
    typedef struct packed { logic [31:0] addr; logic [31:0] data; logic [1:0] size; } st_req_t;

    mem_op_t     mem_q[$];
    ld_rsp_t     ldr_q[$];
    int unsigned std_q[$];
    ld_req_t     ld_pend[$];
    st_req_t     st_pend[$];
    bit          grant_log[$];
    bit          flush_sched[SCHED_LEN];
    int unsigned cyc = 0;
    int unsigned next_free = 0;
    int unsigned st_grant_cyc = 0;
    int          starve = 0;
    bit          ld_gate, st_gate;
    int          n_checks = 0;
    int          n_fail = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_1004) return 32'hA1B2_C3D4;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Behavioural data memory: only answers while a read strobe is up.
    assign data_read_fDM = MemRead_2DM ? mem_word(data_address_2DM) : 32'h0BAD_F00D;

    initial begin
        CLK = 1'b1;
        forever #5 CLK = ~CLK;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, got, exp);
        end
    endtask

    function automatic bit busy();
        return ld_pend.size() > 0 || st_pend.size() > 0 || mem_q.size() > 0 ||
               ldr_q.size() > 0 || std_q.size() > 0;
    endfunction

    task automatic drive_inputs();
        ld_req_valid = ld_gate && (ld_pend.size() > 0);
        st_req_valid = st_gate && (st_pend.size() > 0);
        if (ld_req_valid) begin
            ld_addr = ld_pend[0].addr;
            ld_tag  = ld_pend[0].tag;
        end else begin
            ld_addr = $urandom;
            ld_tag  = TAG_W'($urandom);
        end
        if (st_req_valid) begin
            st_addr = st_pend[0].addr;
            st_data = st_pend[0].data;
            st_size = st_pend[0].size;
        end else begin
            st_addr = $urandom;
            st_data = $urandom;
            st_size = 2'($urandom);
        end
        flush = flush_sched[cyc % SCHED_LEN];
    endtask

    // Reference model: the port is free from next_free on; the priority rule picks the winner.
    task automatic model_step();
        bit free, exp_ld, exp_st, killed;
        if (ld_req_valid && ld_req_ready) grant_log.push_back(1'b0);
        if (st_req_valid && st_req_ready) begin
            grant_log.push_back(1'b1);
            st_grant_cyc = cyc;
        end
        if (RESET) begin
            check("ld_ready_in_reset", 128'(ld_req_ready), 128'(0));
            check("st_ready_in_reset", 128'(st_req_ready), 128'(0));
            next_free = cyc + 1;
            starve    = 0;
            return;
        end
        free   = (cyc >= next_free);
        exp_st = free && st_req_valid && (!ld_req_valid || starve == STARVE_MAX || flush);
        exp_ld = free && !exp_st && ld_req_valid && !flush;
        check("ld_req_ready", 128'(ld_req_ready), 128'(exp_ld));
        check("st_req_ready", 128'(st_req_ready), 128'(exp_st));
        if (exp_ld) begin
            ld_req_t r;
            logic [31:0] wa;
            r      = ld_pend.pop_front();
            wa     = {r.addr[31:2], 2'b00};
            killed = 1'b0;
            for (int k = 1; k <= MEM_LAT; k++) begin
                if (flush_sched[(cyc + k) % SCHED_LEN]) killed = 1'b1;
                mem_q.push_back('{cyc: cyc + k, addr: wa, wdata: 32'h0, size: 2'd0, rd: 1'b1, wr: 1'b0});
            end
            if (!killed) ldr_q.push_back('{cyc: cyc + MEM_LAT + 1, data: mem_word(wa), tag: r.tag});
            if (st_req_valid) starve = (starve < STARVE_MAX) ? starve + 1 : STARVE_MAX;
            next_free = cyc + MEM_LAT + 1;
        end else if (exp_st) begin
            st_req_t s;
            s = st_pend.pop_front();
            for (int k = 1; k <= MEM_LAT; k++) begin
                mem_q.push_back('{cyc: cyc + k, addr: s.addr, wdata: s.data, size: s.size, rd: 1'b0, wr: 1'b1});
            end
            std_q.push_back(cyc + MEM_LAT + 1);
            starve    = 0;
            next_free = cyc + MEM_LAT + 1;
        end
    endtask

    task automatic monitor();
        mem_op_t act, exp;
        ld_rsp_t le;
        forever begin
            @(negedge CLK);
            if (cyc > 0) begin
                act = '{cyc: cyc, addr: data_address_2DM, wdata: data_write_2DM,
                        size: data_write_size_2DM, rd: MemRead_2DM, wr: MemWrite_2DM};
                exp = '0;
                exp.cyc = cyc;
                if (mem_q.size() > 0 && mem_q[0].cyc == cyc) exp = mem_q.pop_front();
                check("mem_port", 128'(act), 128'(exp));

                if (ldr_q.size() > 0 && ldr_q[0].cyc == cyc) begin
                    le = ldr_q.pop_front();
                    check("ld_resp", 128'({ld_resp_valid, ld_resp_data, ld_resp_tag}),
                          128'({1'b1, le.data, le.tag}));
                end else begin
                    check("ld_resp_valid_idle", 128'(ld_resp_valid), 128'(0));
                end

                if (std_q.size() > 0 && std_q[0] == cyc) begin
                    void'(std_q.pop_front());
                    check("st_done", 128'(st_done), 128'(1));
                end else begin
                    check("st_done_idle", 128'(st_done), 128'(0));
                end

                // An access in flight when reset hits is abandoned without a response.
                if (RESET) begin
                    mem_q.delete();
                    ldr_q.delete();
                    std_q.delete();
                end
            end
        end
    endtask

    task automatic tick();
        drive_inputs();
        @(negedge CLK);
        model_step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        ld_gate = 1'b1;
        st_gate = 1'b1;
        while (busy() && n < max_cycles) begin
            tick();
            n++;
        end
        check("drain_complete", 128'(busy()), 128'(0));
    endtask

    initial begin
        int unsigned g;
        logic [7:0] order;

        fork
            monitor();
        join_none

        // Reset with both requesters waiting; the load wins right after release.
        RESET   = 1'b1;
        ld_gate = 1'b1;
        st_gate = 1'b1;
        ld_pend.push_back('{addr: 32'h0000_1006, tag: 4'd5});
        st_pend.push_back('{addr: 32'h0000_2003, data: 32'h0000_00EE, size: 2'd1});
        tick();
        tick();
        check("reset_outputs",
              128'({ld_req_ready, st_req_ready, ld_resp_valid, ld_resp_data, ld_resp_tag, st_done,
                    data_address_2DM, data_write_2DM, data_write_size_2DM, MemRead_2DM, MemWrite_2DM}),
              128'(0));
        RESET = 1'b0;
        drain(40);

        // Both requesters saturated: three loads then a store, repeating.
        grant_log.delete();
        for (int i = 0; i < 10; i++) ld_pend.push_back('{addr: $urandom, tag: TAG_W'($urandom)});
        for (int i = 0; i < 4; i++) st_pend.push_back('{addr: $urandom, data: $urandom, size: 2'($urandom)});
        drain(200);
        order = '0;
        for (int i = 0; i < 8; i++) if (i < grant_log.size()) order[7-i] = grant_log[i];
        check("starve_grant_order", 128'(order), 128'(8'b0001_0001));

        // Flush in the second cycle of a load access kills its response; waiting store follows.
        g = cyc;
        flush_sched[(g + 2) % SCHED_LEN] = 1'b1;
        ld_gate = 1'b1;
        st_gate = 1'b0;
        ld_pend.push_back('{addr: 32'h0000_3008, tag: 4'hA});
        tick();
        st_pend.push_back('{addr: 32'h0000_5550, data: 32'hCAFE_0001, size: 2'd0});
        st_gate = 1'b1;
        tick();
        tick();
        tick();
        check("flush_then_store_grant_cycle", 128'(st_grant_cyc), 128'(g + 3));
        drain(40);

        // Reset in the first access cycle of a store abandons it.
        g = cyc;
        ld_gate = 1'b0;
        st_gate = 1'b1;
        st_pend.push_back('{addr: 32'h0000_4001, data: 32'h1234_5678, size: 2'd2});
        tick();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        check("memwrite_dropped_after_reset", 128'({MemWrite_2DM, MemRead_2DM}), 128'(0));
        for (int i = 0; i < 5; i++) tick();
        drain(40);

        // Randomised traffic with sporadic flushes.
        g = cyc;
        for (int i = 0; i < 600 + MEM_LAT + 5; i++)
            flush_sched[(g + i) % SCHED_LEN] = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < 600; i++) begin
            if (ld_pend.size() < 4 && $urandom_range(0, 2) == 0)
                ld_pend.push_back('{addr: $urandom, tag: TAG_W'($urandom)});
            if (st_pend.size() < 4 && $urandom_range(0, 3) == 0)
                st_pend.push_back('{addr: $urandom, data: $urandom, size: 2'($urandom)});
            ld_gate = ($urandom_range(0, 9) < 7);
            st_gate = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain(300);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
